// File: rtl/mips_hazard_pkg.sv
// Shared definitions for the forwarding/hazard controller: mux select codes,
// register-address width and the shadow pipeline tag entry.
package mips_hazard_pkg;

    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_DEF-1:0] dst;
        logic                  regwrite;
        logic                  memread;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

    // A producer entry supplies src only if it really writes a non-zero register.
    function automatic logic f_match(input logic use_i, input logic [REG_AW_DEF-1:0] src,
                                     input tag_t e);
        return use_i && e.valid && e.regwrite && (e.dst == src) && (src != '0);
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_pipe_tag_stage.sv
// One shadow pipeline tag register with load, bubble, hold and sync reset.
module pipe_tag_stage
    import mips_hazard_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_hold,
    input  logic i_bubble,
    input  tag_t i_d,
    output tag_t o_q
);

    tag_t r_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_q <= '0;
        else if (!i_hold)
            r_q <= i_bubble ? '0 : i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / load-use hazard controller for the 5-stage MIPS-lite pipeline.
// Optional stall counter enabled by defining HAZ_STALL_CNT_EN.
module fwd_hazard_ctrl
    import mips_hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_hold,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_regwrite,
    input  logic              id_memread,
    output logic              stall,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_count
);

    tag_t       w_id_tag, w_ex_tag, w_mem_tag, w_wb_tag;
    logic       w_stall, w_id_bubble;
    logic [1:0] w_a_nxt, w_b_nxt;
    logic [1:0] r_fwd_a_sel, r_fwd_b_sel;

    assign w_id_tag = '{valid: id_valid, dst: id_dst, regwrite: id_regwrite, memread: id_memread};

    // Load in EX feeding the instruction in ID; flush kills the consumer so it wins.
    assign w_stall = id_valid && !flush && w_ex_tag.valid && w_ex_tag.memread &&
                     (f_match(id_use_rs, id_rs, w_ex_tag) || f_match(id_use_rt, id_rt, w_ex_tag));
    assign w_id_bubble = w_stall || flush || !id_valid;

    pipe_tag_stage u_ex  (.clk(clk), .rst_n(rst_n), .i_hold(pipe_hold), .i_bubble(w_id_bubble),
                          .i_d(w_id_tag),  .o_q(w_ex_tag));
    pipe_tag_stage u_mem (.clk(clk), .rst_n(rst_n), .i_hold(pipe_hold), .i_bubble(1'b0),
                          .i_d(w_ex_tag),  .o_q(w_mem_tag));
    pipe_tag_stage u_wb  (.clk(clk), .rst_n(rst_n), .i_hold(pipe_hold), .i_bubble(1'b0),
                          .i_d(w_mem_tag), .o_q(w_wb_tag));

    // Current EX becomes next MEM, current MEM becomes next WB; nearer producer wins.
    always_comb begin
        w_a_nxt = FWD_REGFILE;
        w_b_nxt = FWD_REGFILE;
        if (!w_id_bubble) begin
            if (f_match(id_use_rs, id_rs, w_ex_tag))       w_a_nxt = FWD_MEM;
            else if (f_match(id_use_rs, id_rs, w_mem_tag)) w_a_nxt = FWD_WB;
            if (f_match(id_use_rt, id_rt, w_ex_tag))       w_b_nxt = FWD_MEM;
            else if (f_match(id_use_rt, id_rt, w_mem_tag)) w_b_nxt = FWD_WB;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fwd_a_sel <= FWD_REGFILE;
            r_fwd_b_sel <= FWD_REGFILE;
        end else if (!pipe_hold) begin
            r_fwd_a_sel <= w_a_nxt;
            r_fwd_b_sel <= w_b_nxt;
        end
    end

    assign stall     = w_stall;
    assign fwd_a_sel = r_fwd_a_sel;
    assign fwd_b_sel = r_fwd_b_sel;

`ifdef HAZ_STALL_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (w_stall && !pipe_hold && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end

    assign stall_count = r_stall_cnt;
`else
    assign stall_count = '0;
`endif

endmodule
